// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: tick-driven digit scan, frame-synchronous
// double buffering, leading-zero blanking. Define SEG_PWM_EN to add PWM brightness on an.
module seg_scan_ctrl #(
    parameter int DIGITS     = 8,
    parameter int DIV_W      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic                load,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                blank_lz,
    input  logic [3:0]          bright,
    output logic [6:0]          a2g,
    output logic                dp,
    output logic [DIGITS-1:0]   an,
    output logic                frame_done
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] disp_data, shad_data;
    logic [DIGITS-1:0]   disp_dp, shad_dp;
    logic                pending;
    logic                tick, wrap;

    assign tick = &cnt;
    assign wrap = tick && (idx == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= '0;
            disp_data <= '0;
            shad_data <= '0;
            disp_dp   <= '0;
            shad_dp   <= '0;
            pending   <= 1'b0;
        end else begin
            cnt <= cnt + DIV_W'(1);
            if (tick)
                idx <= wrap ? '0 : idx + IDX_W'(1);
            // A load landing on the wrap tick bypasses the shadow so it is not delayed a frame
            if (load && wrap) begin
                disp_data <= data_in;
                shad_data <= data_in;
                disp_dp   <= dp_in;
                shad_dp   <= dp_in;
                pending   <= 1'b0;
            end else if (load) begin
                shad_data <= data_in;
                shad_dp   <= dp_in;
                pending   <= 1'b1;
            end else if (wrap && pending) begin
                disp_data <= shad_data;
                disp_dp   <= shad_dp;
                pending   <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h7E;
            4'h1:    return 7'h30;
            4'h2:    return 7'h6D;
            4'h3:    return 7'h79;
            4'h4:    return 7'h33;
            4'h5:    return 7'h5B;
            4'h6:    return 7'h5F;
            4'h7:    return 7'h70;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h7B;
            4'hA:    return 7'h77;
            4'hB:    return 7'h1F;
            4'hC:    return 7'h4E;
            4'hD:    return 7'h3D;
            4'hE:    return 7'h4F;
            default: return 7'h47;
        endcase
    endfunction

    logic pwm_on;
`ifdef SEG_PWM_EN
    assign pwm_on = (cnt[DIV_W-1 -: 4] <= bright);
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign pwm_on = 1'b1;
`endif

    logic [3:0]        cur_nib;
    logic              cur_dp, cur_blank, zero_run, blank_i;
    logic [DIGITS-1:0] an_hi;

    // zero_run stays set while every digit from the left so far is zero
    always_comb begin
        zero_run  = 1'b1;
        blank_i   = 1'b0;
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_hi     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            zero_run = zero_run && (disp_data[4*(DIGITS-1-i) +: 4] == 4'h0);
            blank_i  = blank_lz && zero_run && (i != DIGITS - 1) && !disp_dp[DIGITS-1-i];
            if (idx == IDX_W'(i)) begin
                cur_nib   = disp_data[4*(DIGITS-1-i) +: 4];
                cur_dp    = disp_dp[DIGITS-1-i];
                cur_blank = blank_i;
                an_hi[DIGITS-1-i] = !blank_i && pwm_on;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a2g        <= {7{POL}};
            dp         <= POL;
            an         <= {DIGITS{POL}};
            frame_done <= 1'b0;
        end else begin
            a2g        <= (cur_blank ? 7'h00 : seg_decode(cur_nib)) ^ {7{POL}};
            dp         <= (cur_dp && !cur_blank) ^ POL;
            an         <= an_hi ^ {DIGITS{POL}};
            frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (DIGITS=4, DIV_W=4, active-low outputs).
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bright = 4'hF;
    logic [6:0]  a2g;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    seg_scan_ctrl #(.DIGITS(4), .DIV_W(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .bright(bright), .a2g(a2g), .dp(dp), .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [12:0] sb[$];
    logic [12:0] ex;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    int          m_cnt, m_idx;
    logic [15:0] m_disp, m_sh;
    logic [3:0]  m_ddp, m_shdp;
    logic        m_pend;

    // Predicts {an, a2g, dp, frame_done} after the coming edge and advances model state
    task automatic model_edge();
        logic [3:0] an_e, nib;
        logic [6:0] seg_e;
        logic       dp_e, tick, wrap, zr, blank, pwm_ok;
        int         pos;
        if (rst) begin
            sb.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
            m_cnt = 0; m_idx = 0; m_disp = '0; m_sh = '0; m_ddp = '0; m_shdp = '0; m_pend = 1'b0;
            return;
        end
        tick = (m_cnt == 15);
        wrap = tick && (m_idx == 3);
        pos  = 3 - m_idx;
        nib  = m_disp[4*pos +: 4];
        zr   = 1'b1;
        for (int k = 0; k <= m_idx; k++)
            if (m_disp[4*(3-k) +: 4] != 4'h0) zr = 1'b0;
        blank = blank_lz && zr && (m_idx != 3) && !m_ddp[pos];
`ifdef SEG_PWM_EN
        pwm_ok = (m_cnt <= int'(bright));
`else
        pwm_ok = 1'b1;
`endif
        an_e = 4'hF;
        if (!blank && pwm_ok) an_e[pos] = 1'b0;
        seg_e = blank ? 7'h7F : ~seg_tab[nib];
        dp_e  = blank ? 1'b1 : ~m_ddp[pos];
        sb.push_back({an_e, seg_e, dp_e, wrap});
        m_cnt = (m_cnt + 1) % 16;
        if (tick) m_idx = wrap ? 0 : m_idx + 1;
        if (load && wrap) begin
            m_disp = data_in; m_sh = data_in; m_ddp = dp_in; m_shdp = dp_in; m_pend = 1'b0;
        end else if (load) begin
            m_sh = data_in; m_shdp = dp_in; m_pend = 1'b1;
        end else if (wrap && m_pend) begin
            m_disp = m_sh; m_ddp = m_shdp; m_pend = 1'b0;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            ex = sb.pop_front(); n_cmp++;
            if ({an, a2g, dp, frame_done} !== ex) begin
                n_err++; $display("FAIL sb_reset got=%h exp=%h", {an, a2g, dp, frame_done}, ex);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({an, a2g, dp, frame_done} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL reset_first_cycle got=%b exp=1111111111110", {an, a2g, dp, frame_done});
        end
        cyc();
        ex = sb.pop_front(); n_cmp++;
        if ({an, a2g, dp, frame_done} !== ex) begin
            n_err++; $display("FAIL sb_reset_release got=%h exp=%h", {an, a2g, dp, frame_done}, ex);
        end
        n_cmp++;
        if (an !== 4'b0111 || a2g !== 7'b0000001) begin
            n_err++; $display("FAIL reset_digit0 an=%b a2g=%b exp an=0111 a2g=0000001", an, a2g);
        end
    endtask

    task automatic test_double_buffer();
        int fd_cnt = 0;
        do_reset();
        blank_lz = 1'b0; dp_in = 4'b0000;
        for (int t = 1; t <= 140; t++) begin
            load = (t == 5);
            data_in = (t == 5) ? 16'h12AF : 16'h0000;
            cyc();
            ex = sb.pop_front(); n_cmp++;
            if ({an, a2g, dp, frame_done} !== ex) begin
                n_err++; $display("FAIL sb_dbuf t=%0d got=%h exp=%h", t, {an, a2g, dp, frame_done}, ex);
            end
            if (frame_done) fd_cnt++;
            if (t == 60) begin
                n_cmp++;
                if (a2g !== 7'b0000001) begin n_err++; $display("FAIL dbuf_old t=60 a2g=%b exp=0000001", a2g); end
            end
            if (t == 64 || t == 128) begin
                n_cmp++;
                if (frame_done !== 1'b1) begin n_err++; $display("FAIL dbuf_fd t=%0d got=%b exp=1", t, frame_done); end
            end
            if (t == 65 || t == 81 || t == 97 || t == 113) begin
                logic [10:0] want;
                case (t)
                    65:      want = {4'b0111, 7'b1001111};
                    81:      want = {4'b1011, 7'b0010010};
                    97:      want = {4'b1101, 7'b0001000};
                    default: want = {4'b1110, 7'b0111000};
                endcase
                n_cmp++;
                if ({an, a2g} !== want) begin
                    n_err++; $display("FAIL dbuf_slot t=%0d got=%b exp=%b", t, {an, a2g}, want);
                end
            end
        end
        load = 1'b0;
        n_cmp++;
        if (fd_cnt != 2) begin n_err++; $display("FAIL dbuf_fd_count got=%0d exp=2", fd_cnt); end
    endtask

    task automatic test_lz();
        logic [15:0] dv [3] = '{16'h0050, 16'h0000, 16'h0000};
        logic [3:0]  pv [3] = '{4'b0000, 4'b0000, 4'b0100};
        int          want_bl [3] = '{32, 48, 32};
        for (int c = 0; c < 3; c++) begin
            int bl = 0;
            do_reset();
            blank_lz = 1'b1;
            for (int t = 1; t <= 128; t++) begin
                load = (t == 1);
                data_in = dv[c]; dp_in = pv[c];
                cyc();
                ex = sb.pop_front(); n_cmp++;
                if ({an, a2g, dp, frame_done} !== ex) begin
                    n_err++; $display("FAIL sb_lz c=%0d t=%0d got=%h exp=%h", c, t, {an, a2g, dp, frame_done}, ex);
                end
                if (t > 64 && an == 4'hF) bl++;
                if (c == 0 && t == 97) begin
                    n_cmp++;
                    if (an !== 4'b1101 || a2g !== 7'b0100100) begin
                        n_err++; $display("FAIL lz_five an=%b a2g=%b exp an=1101 a2g=0100100", an, a2g);
                    end
                end
                if (c == 1 && t == 113) begin
                    n_cmp++;
                    if (an !== 4'b1110 || a2g !== 7'b0000001) begin
                        n_err++; $display("FAIL lz_last an=%b a2g=%b exp an=1110 a2g=0000001", an, a2g);
                    end
                end
                if (c == 2 && t == 81) begin
                    n_cmp++;
                    if (an !== 4'b1011 || dp !== 1'b0) begin
                        n_err++; $display("FAIL lz_dp an=%b dp=%b exp an=1011 dp=0", an, dp);
                    end
                end
            end
            load = 1'b0;
            n_cmp++;
            if (bl != want_bl[c]) begin n_err++; $display("FAIL lz_count c=%0d got=%0d exp=%0d", c, bl, want_bl[c]); end
        end
        blank_lz = 1'b0; dp_in = 4'b0000;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int t = 1; t <= 220; t++) begin
            load = (t == 5) || (t == 64) || (t == 150);
            data_in = (t == 5) ? 16'h1111 : (t == 64) ? 16'h7777 : 16'hFFFF;
            rst = (t == 150);
            cyc();
            ex = sb.pop_front(); n_cmp++;
            if ({an, a2g, dp, frame_done} !== ex) begin
                n_err++; $display("FAIL sb_simul t=%0d got=%h exp=%h", t, {an, a2g, dp, frame_done}, ex);
            end
            if (t == 65 || t == 129) begin
                n_cmp++;
                if (a2g !== 7'b0001111) begin n_err++; $display("FAIL simul_seven t=%0d a2g=%b exp=0001111", t, a2g); end
            end
            if (t == 150) begin
                n_cmp++;
                if ({an, a2g, dp, frame_done} !== 13'b1111_1111111_1_0) begin
                    n_err++; $display("FAIL simul_rst got=%b exp=1111111111110", {an, a2g, dp, frame_done});
                end
            end
            if (t == 151 || t == 215) begin
                n_cmp++;
                if (an !== 4'b0111 || a2g !== 7'b0000001) begin
                    n_err++; $display("FAIL simul_after_rst t=%0d an=%b a2g=%b exp an=0111 a2g=0000001", t, an, a2g);
                end
            end
        end
        load = 1'b0; rst = 1'b0;
    endtask

    task automatic test_pwm();
        logic [3:0] bv [3] = '{4'd3, 4'd15, 4'd0};
`ifdef SEG_PWM_EN
        int want [3] = '{16, 64, 4};
`else
        int want [3] = '{64, 64, 64};
`endif
        for (int c = 0; c < 3; c++) begin
            int on = 0;
            do_reset();
            bright = bv[c];
            for (int t = 1; t <= 64; t++) begin
                cyc();
                ex = sb.pop_front(); n_cmp++;
                if ({an, a2g, dp, frame_done} !== ex) begin
                    n_err++; $display("FAIL sb_pwm c=%0d t=%0d got=%h exp=%h", c, t, {an, a2g, dp, frame_done}, ex);
                end
                if (an != 4'hF) on++;
            end
            n_cmp++;
            if (on != want[c]) begin n_err++; $display("FAIL pwm_duty bright=%0d got=%0d exp=%0d", bv[c], on, want[c]); end
        end
        bright = 4'hF;
    endtask

    initial begin
        test_reset();
        test_double_buffer();
        test_lz();
        test_simultaneous();
        test_pwm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Parametrised multiplexed seven-segment display controller for the SCPU debug display path. It supersedes the fixed 8-digit `segment` plus `clkdiv` pair. Digit scanning runs off a clock-enable tick in the `clk` domain, so no divided clock is generated. Data written by the core is double-buffered and swapped only at frame boundaries, which prevents tearing. Leading-zero blanking, per-digit decimal points and optional PWM brightness are included.

## Interface
- `DIGITS`, default 8: number of digits, legal range 1..8.
- `DIV_W`, default 16: each digit slot lasts 2^DIV_W `clk` cycles; minimum 4.
- `ACTIVE_LOW`, default 1: when 1, `a2g`, `dp` and `an` are driven active-low.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `data_in` in 4*DIGITS: hex nibbles; MSB nibble is digit 0 (leftmost).
- `load` in 1: single-cycle strobe; captures `data_in` and `dp_in`.
- `dp_in` in DIGITS: decimal-point enables; bit DIGITS-1-i maps to digit i.
- `blank_lz` in 1: enables leading-zero suppression.
- `bright` in 4: brightness level; used only when `SEG_PWM_EN` is defined.
- `a2g` out 7: segments; bit6 = a … bit0 = g.
- `dp` out 1: decimal-point segment.
- `an` out DIGITS: digit enables; an[DIGITS-1-i] drives digit i.
- `frame_done` out 1: one-cycle pulse on every frame wrap.

## Operation
- Slot counter `cnt` is DIV_W bits, free-running from 0 to 2^DIV_W−1 and wrapping to 0.
  - `tick` = (`cnt` == all ones).
- Digit index `idx` advances on `tick` and wraps from DIGITS−1 to 0.
  - A wrap tick pulses `frame_done`.
- Buffering:
  - `load` writes `data_in`/`dp_in` into the shadow register and sets `pending`.
  - On a wrap tick with `pending`=1: display ← shadow, `pending` ← 0.
  - `load` on the same cycle as a wrap tick writes `data_in` directly to both display and shadow, and `pending` stays 0.
  - A second `load` before the swap overwrites the shadow; the last value wins.
- Decode uses active-high patterns, inverted when ACTIVE_LOW:
  - 0 = 7E, 1 = 30, 2 = 6D, 3 = 79, 4 = 33, 5 = 5B, 6 = 5F, 7 = 70
  - 8 = 7F, 9 = 7B, A = 77, b = 1F, C = 4E, d = 3D, E = 4F, F = 47
- Leading-zero blanking (`blank_lz`=1):
  - Digits left of the first nonzero display nibble are blanked: `an` inactive, `a2g`/`dp` off.
  - Digit DIGITS−1 is never blanked.
  - A digit with its display dp bit set is never blanked.
- The blanking decision is evaluated from the display register only, never from the shadow.

## Timing
- All outputs are registered and reflect the `idx`/`cnt` values of the previous cycle (1-cycle latency).
- Reset values:
  - `cnt`=0, `idx`=0, display=0, shadow=0, `pending`=0.
  - `an` all inactive, `a2g` off, `dp` off, `frame_done`=0.
- The first cycle after `rst` deasserts produces outputs still at their reset values. From the second cycle, digit 0 is lit with display 0.
- From `load` to visible: the update appears at the next wrap tick plus 1 cycle. Worst case is DIGITS·2^DIV_W + 1 cycles.
- `rst` asserted mid-frame:
  - Aborts the frame and discards the shadow and `pending`.
  - Takes precedence over a simultaneous `load`.
- `DIGITS`=1: every tick is a wrap tick, so `frame_done` pulses once per 2^DIV_W cycles.

## Configuration
- `SEG_PWM_EN` defined:
  - Within each slot, `an` is active only while `cnt[DIV_W-1 -: 4]` ≤ `bright`.
  - `bright`=15 gives full on; `bright`=0 gives 1/16 duty.
  - `a2g`/`dp` are unaffected.
  - `bright` is sampled every cycle.
- `SEG_PWM_EN` undefined:
  - `bright` is ignored and may be left unconnected.
  - `an` is active for the whole slot.

## Test plan
Bench parameters: DIGITS=4, DIV_W=4, ACTIVE_LOW=1.
- Reset check: hold `rst` 3 cycles → `an`=4'b1111, `a2g`=7'b1111111, `dp`=1, `frame_done`=0. Cycle 2 after release → `an`=4'b0111, `a2g`=~7E=7'b0000001.
- Double buffering: `load` 0x12AF at cycle 5 → digits keep showing 0 until the wrap at cycle 63. Then the slots show 1 (`a2g`=7'b1001111), 2, A, F, each for 16 cycles with `an` 0111→1011→1101→1110, and `frame_done` pulses every 64 cycles.
- Leading-zero blanking: `blank_lz`=1 with 0x0050 → digits 0–1 have `an` inactive, digit 2 shows 5 and digit 3 shows 0. With 0x0000 → only digit 3 is lit, showing 0. With `dp_in`=4'b0100 and 0x0000 → digits 1 and 3 are lit.
- Simultaneous events: `load` 0x7777 on the wrap-tick cycle while `pending` holds 0x1111 → the next frame shows 7777 and `pending`=0. Also: `rst` together with `load` mid-frame → reset values, and display stays 0.
- PWM (`SEG_PWM_EN`): `bright`=3 → `an` active for exactly 4 of every 16 cycles per slot. `bright`=15 → active 16/16. Without the macro, `bright`=0 → active 16/16.
